// File: rtl/rr_arb4_2x.sv
// rr_arb4_2x: four-requester round-robin arbiter with bounded hold time.
// Grants one client at a time and holds until DONE, a request drop, or
// MAX_HOLD cycles, then inserts one all-zero guard cycle before the next grant.
// Optional feature macro: RR_ARB_LOCK_EN (adds LOCK input that freezes the
// hold counter while asserted in GRANT).
module rr_arb4_2x #(
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [3:0] REQ,
    input  logic       DONE,
`ifdef RR_ARB_LOCK_EN
    input  logic       LOCK,
`endif
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       BUSY,
    output logic       TMO
);

    localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [3:0]        gnt_nxt;
    logic [1:0]        id_nxt;
    logic              busy_nxt;
    logic              tmo_nxt;

    logic              pick_vld;
    logic [1:0]        pick_idx;
    logic              lock_act;
    logic              owner_req;

`ifdef RR_ARB_LOCK_EN
    assign lock_act = LOCK;
`else
    assign lock_act = 1'b0;
`endif

    // Requester currently holding the grant still asserting its request line
    assign owner_req = REQ[GNT_ID];

    // Rotating priority pick: first requester at or after ptr, modulo 4
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!pick_vld && REQ[ptr + 2'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr + 2'(i);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = GNT;
        id_nxt    = GNT_ID;
        busy_nxt  = BUSY;
        tmo_nxt   = 1'b0;

        unique case (state)
            ST_IDLE, ST_GAP: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (pick_vld) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = 4'b0001 << pick_idx;
                    id_nxt    = pick_idx;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = HOLD_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (DONE || !owner_req) begin
                    // Normal release has priority over a coincident timeout
                    state_nxt = ST_GAP;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = GNT_ID + 2'd1;
                end else if (!lock_act && (cnt >= MAX_CNT)) begin
                    state_nxt = ST_GAP;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    tmo_nxt   = 1'b1;
                    ptr_nxt   = GNT_ID + 2'd1;
                end else if (!lock_act) begin
                    cnt_nxt = cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            cnt    <= '0;
            GNT    <= '0;
            GNT_ID <= '0;
            BUSY   <= 1'b0;
            TMO    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            GNT    <= gnt_nxt;
            GNT_ID <= id_nxt;
            BUSY   <= busy_nxt;
            TMO    <= tmo_nxt;
        end
    end

    // Structural invariants of the grant outputs
    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(GNT));
    a_gnt_busy:   assert property (@(posedge CLK) disable iff (!RSTN) ((GNT != 4'b0000) == BUSY));
    a_tmo_idle:   assert property (@(posedge CLK) disable iff (!RSTN) (TMO |-> !BUSY));

endmodule

// File: tb/tb_rr_arb4_2x.sv
// Self-checking bench for rr_arb4_2x: directed scenarios plus randomized
// traffic compared against a grant-holder reference model.
module tb_rr_arb4_2x;

    localparam int MAX_HOLD = 15;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       done;
    logic       lock;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how long, and where the
    // round-robin search starts next.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_last  = 0;
    bit m_tmo   = 0;

    rr_arb4_2x #(.HOLD_W(4), .MAX_HOLD(15)) dut (
        .CLK    (clk),
        .RSTN   (rstn),
        .REQ    (req),
        .DONE   (done),
`ifdef RR_ARB_LOCK_EN
        .LOCK   (lock),
`endif
        .GNT    (gnt),
        .GNT_ID (gnt_id),
        .BUSY   (busy),
        .TMO    (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        m_tmo = 0;
        if (!rstn) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner]) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1;
            end else if (!lock && m_held == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1; m_tmo = 1;
            end else if (!lock) begin
                m_held++;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                int c;
                c = (m_ptr + j) % 4;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_held = 1; m_last = c;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_last), (m_owner >= 0), m_tmo};
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rstn = 0; req = '0; done = 0; lock = 0;
        tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        rstn = 0; req = 4'b1111; done = 0; lock = 0;
        tick(); tick();
        checks++;
        if ({gnt, gnt_id, busy, tmo} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b id=%0d busy=%b tmo=%b, want all zero", gnt, gnt_id, busy, tmo);
        end
        rstn = 1;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got gnt=%b, want 0001", gnt);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        logic [3:0] prev;
        int hi, lo, tmos;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111; prev = '0; hi = 0; lo = 0; tmos = 0;
        for (int t = 0; t < 19; t++) begin
            tick();
            done = (m_owner >= 0 && m_held == 3);
            checks++;
            if ({gnt, gnt_id, busy, tmo} !== model_vec()) begin
                errors++;
                $display("FAIL fair_model t=%0d: got %h, want %h", t, {gnt, gnt_id, busy, tmo}, model_vec());
            end
            if (gnt != 0 && prev == 0) order.push_back(onehot_idx(gnt));
            if (gnt != 0) hi++; else lo++;
            if (tmo) tmos++;
            prev = gnt;
        end
        done = 0;
        checks++;
        if (order.size() != 5 || hi != 15 || lo != 4 || tmos != 0) begin
            errors++;
            $display("FAIL fair_counts: got grants=%0d hi=%0d lo=%0d tmo=%0d, want 5 15 4 0", order.size(), hi, lo, tmos);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= order.size() || order[i] != exp_order[i]) begin
                errors++;
                $display("FAIL fair_order[%0d]: got %0d, want %0d", i, (i < order.size()) ? order[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req = 4'b0100;
        tick();
        n = 0;
        while (gnt !== 4'b0000 && n < 40) begin
            checks++;
            if (gnt !== 4'b0100 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold n=%0d: got gnt=%b tmo=%b, want 0100 0", n, gnt, tmo);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 15 || tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_release: got len=%0d tmo=%b, want 15 1", n, tmo);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || tmo !== 1'b0 || {gnt, gnt_id, busy, tmo} !== model_vec()) begin
            errors++;
            $display("FAIL tmo_regrant: got gnt=%b tmo=%b, want 0100 0", gnt, tmo);
        end
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        req = 4'b0100;
        tick();
        n = 0;
        while (!(m_owner >= 0 && m_held == MAX_HOLD) && n < 40) begin
            n++;
            tick();
        end
        done = 1;
        tick();
        done = 0;
        checks++;
        if (n != 14 || gnt !== 4'b0000 || tmo !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL collision: got n=%0d gnt=%b tmo=%b busy=%b, want 14 0000 0 0", n, gnt, tmo, busy);
        end
    endtask

    task automatic test_drop_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL wrap_grant3: got gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0000 || tmo !== 1'b0 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL wrap_drop: got gnt=%b tmo=%b id=%0d, want 0000 0 3", gnt, tmo, gnt_id);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_regrant: got gnt=%b id=%0d, want 0001 0", gnt, gnt_id);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0100;
        tick(); tick();
        rstn = 0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || tmo !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_drop: got gnt=%b tmo=%b busy=%b id=%0d, want 0000 0 0 0", gnt, tmo, busy, gnt_id);
        end
        rstn = 1; req = 4'b1100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL midrst_regrant: got gnt=%b id=%0d, want 0100 2", gnt, gnt_id);
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        int n;
        do_reset();
        req = 4'b0010; lock = 1;
        for (int t = 0; t < 25; t++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold t=%0d: got gnt=%b tmo=%b, want 0010 0", t, gnt, tmo);
            end
        end
        do_reset();
        req = 4'b0010; lock = 0;
        for (int t = 0; t < 5; t++) tick();
        lock = 1;
        for (int t = 0; t < 20; t++) tick();
        lock = 0;
        n = 0;
        tick();
        while (gnt !== 4'b0000 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 10 || tmo !== 1'b1) begin
            errors++;
            $display("FAIL lock_resume: got extra=%0d tmo=%b, want 10 1", n, tmo);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            rstn = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 11) == 0);
`ifdef RR_ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`else
            lock = 0;
`endif
            tick();
            checks++;
            if ({gnt, gnt_id, busy, tmo} !== model_vec()) begin
                errors++;
                $display("FAIL random_model t=%0d: got %h, want %h", t, {gnt, gnt_id, busy, tmo}, model_vec());
            end
        end
        rstn = 1; done = 0; lock = 0;
    endtask

    initial begin
        rstn = 0; req = '0; done = 0; lock = 0;
        test_reset();
        test_fairness();
        test_timeout();
        test_collision();
        test_drop_wrap();
        test_mid_reset();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb4_2x.md
Name: rr_arb4_2x

Overview:
- Four-requester round-robin arbiter sharing one datapath resource (e.g. a shared and4_2x/nand_2x logic slice or a shared bus driver) among four client blocks.
- Grants one requester at a time, holds the grant until the client signals DONE or drops its request, and enforces a bounded hold time.
- Sits between the client request lines and the resource's select/enable logic.
- Registered outputs only; single clock domain.

Parameters:
- HOLD_W, 4, width of the hold counter.
- MAX_HOLD, 15, maximum cycles GNT may stay high for one grant; legal range 1 to 2^HOLD_W-1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTN  input  1  synchronous active-low reset.
- REQ  input  4  request lines; bit i is requester i; level-sensitive.
- DONE  input  1  resource finished for the current grant; sampled only in GRANT.
- GNT  output  4  one-hot grant; all-zero when nothing is granted.
- GNT_ID  output  2  index of the current or most recent grant.
- BUSY  output  1  high while in GRANT.
- TMO  output  1  one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- Interface: one clock CLK; reset RSTN is synchronous and active-low.
- Reset: sampled on the CLK edge with RSTN=0. Resets GNT=0, GNT_ID=0, BUSY=0, TMO=0, state=IDLE, priority pointer PTR=0, hold counter CNT=0.
- Reset mid-grant: the grant is dropped on that edge with no TMO, and PTR returns to 0.
- States: IDLE, GRANT, GAP.
- Arbitration (IDLE and GAP only):
  - Pick the first i with REQ[i]=1, scanning PTR, PTR+1, ... mod 4.
  - If a requester is picked: next cycle GNT=one-hot(i), GNT_ID=i, BUSY=1, CNT=1, state=GRANT.
  - If none: next state IDLE.
- Latency: a REQ seen in IDLE produces GNT on the next cycle (1-cycle latency).
- GRANT, with k = number of cycles GNT has been high, CNT tracks k. Release conditions, in priority order:
  - DONE=1, or REQ[GNT_ID]=0: normal release; next cycle GNT=0, BUSY=0, TMO=0, state=GAP.
  - Otherwise, if CNT==MAX_HOLD: timeout release; next cycle GNT=0, BUSY=0, TMO=1, state=GAP.
  - Otherwise: CNT increments and the grant holds.
- DONE and timeout in the same cycle: DONE wins and TMO stays 0.
- GNT can never exceed MAX_HOLD consecutive cycles.
- On any release, PTR = (GNT_ID+1) mod 4. PTR is unchanged at all other times.
- GAP:
  - Exactly one guard cycle with GNT=0.
  - Arbitration runs using the updated PTR.
  - Back-to-back grants are therefore separated by exactly one all-zero GNT cycle.
- TMO is high only in the GAP cycle that follows a timeout; 0 otherwise.
- GNT_ID keeps the last granted index through GAP and IDLE; it changes only on a new grant.
- DONE outside GRANT is ignored.
- REQ changes on non-granted lines never affect the current grant.
- At most one GNT bit is ever high. GNT!=0 if and only if BUSY=1.
- CNT saturates at MAX_HOLD and never wraps.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds port LOCK (input, 1 bit).
  - While LOCK=1 in GRANT, CNT is frozen and timeout cannot fire, so the client holds the resource until DONE or request drop.
  - When LOCK returns to 0, counting resumes from the frozen value.
  - LOCK has no effect in IDLE or GAP.
- Not defined: no LOCK port; timeout is always active as described above.

Test Plan:
- Reset: hold RSTN=0 for 2 cycles with REQ=4'b1111 -> GNT=0, GNT_ID=0, BUSY=0, TMO=0. After release: GNT=4'b0001 one cycle later.
- Round-robin fairness: REQ=4'b1111 held, DONE pulsed on the 3rd cycle of each grant -> grants in order 0,1,2,3,0. Each GNT is high 3 cycles, with one GNT=0 cycle between grants, and TMO stays 0.
- Timeout: REQ=4'b0100, DONE=0, MAX_HOLD=15 -> GNT=4'b0100 for exactly 15 cycles, then GNT=0 with TMO=1 for one cycle, then GNT=4'b0100 again.
- DONE/timeout collision: DONE=1 on grant cycle 15 -> release with TMO=0.
- Request drop and PTR wrap: grant requester 3, then drop REQ[3] with REQ=4'b0001 -> GNT=0 next cycle, then GNT=4'b0001 (PTR wrapped to 0).
- Mid-grant reset: RSTN=0 during grant to requester 2 -> GNT=0 and TMO=0 next cycle. After release with REQ=4'b1100: grant goes to requester 2 (PTR=0 scan).
- With RR_ARB_LOCK_EN: LOCK=1 for 20 cycles with REQ=4'b0010 -> GNT held 20+ cycles with no TMO. After LOCK=0 at CNT=5: timeout fires after 10 more cycles.
